// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART command parser acting as a Wishbone master, with replies and a CPU jump strobe
module uart_wb_bridge #(
  parameter int rx_timeout = 1000000,
  parameter int wb_timeout = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic [31:0] jump_adr,
  output logic        jump_stb
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WB, JUMP, TX} state_t;
  localparam int rw = $clog2(rx_timeout + 1);
  localparam int ww = $clog2(wb_timeout + 1);
  localparam logic [rw-1:0] rx_last = rw'(rx_timeout - 1);
  localparam logic [ww-1:0] wb_last = ww'(wb_timeout - 1);
  localparam logic [7:0] cmd_r = 8'h72, cmd_w = 8'h77, cmd_g = 8'h67;
  state_t state, state_n;
  logic [7:0] cmd;
  logic [31:0] adr, dat, reply;
  logic [1:0] cnt, idx, tx_last;
  logic [rw-1:0] rx_tmr;
  logic [ww-1:0] wb_tmr;
  logic cyc, take, ack, expire, rx_exp, send;
  assign wb_adr_o = adr;
  assign wb_dat_o = dat;
  assign wb_sel_o = 4'hF;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o = cyc && cmd == cmd_w;
  always_comb begin
    take = rx_avail && !rx_ack && (state == IDLE || state == ADDR || state == DATA);
    ack = state == WB && wb_ack_i;
    expire = state == WB && !wb_ack_i && wb_tmr == wb_last;
    rx_exp = (state == ADDR || state == DATA) && !take && rx_tmr == rx_last;
    send = state == TX && !tx_busy && !tx_wr;
    state_n = state;
    case (state)
      IDLE: state_n = take && (rx_data == cmd_r || rx_data == cmd_w || rx_data == cmd_g) ? ADDR : IDLE;
      ADDR: state_n = take && cnt == 2'd3 ? (cmd == cmd_w ? DATA : cmd == cmd_g ? JUMP : WB) : rx_exp ? IDLE : ADDR;
      DATA: state_n = take && cnt == 2'd3 ? WB : rx_exp ? IDLE : DATA;
      WB:   state_n = ack || expire ? TX : WB;
      JUMP: state_n = IDLE;
      TX:   state_n = send && idx == tx_last ? IDLE : TX;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd <= '0;
      adr <= '0;
      dat <= '0;
      reply <= '0;
      cnt <= '0;
      idx <= '0;
      tx_last <= '0;
      rx_tmr <= '0;
      wb_tmr <= '0;
      cyc <= 1'b0;
      rx_ack <= 1'b0;
      tx_wr <= 1'b0;
      tx_data <= '0;
      jump_adr <= '0;
      jump_stb <= 1'b0;
    end else begin
      state <= state_n;
      rx_ack <= take;
      tx_wr <= send;
      cyc <= state_n == WB;
      jump_stb <= state_n == JUMP;
      cnt <= state_n == IDLE ? 2'd0 : take && state != IDLE ? cnt + 2'd1 : cnt;
      // a consumed byte always restarts the inter-byte timer, even in the expiry cycle
      rx_tmr <= (state == ADDR || state == DATA) && !take && !rx_exp ? rx_tmr + 1'b1 : '0;
      wb_tmr <= state == WB ? wb_tmr + 1'b1 : '0;
      idx <= state == TX ? idx + 2'(send) : 2'd0;
      if (take && state == IDLE) cmd <= rx_data;
      if (take && state == ADDR) adr <= {adr[23:0], rx_data};
      if (take && state == DATA) dat <= {dat[23:0], rx_data};
      if (state_n == JUMP) jump_adr <= {adr[23:0], rx_data};
      if (send) tx_data <= reply[31:24];
      if (ack) begin
        reply <= cmd == cmd_w ? {8'h6B, 24'h0} : wb_dat_i;
        tx_last <= cmd == cmd_w ? 2'd0 : 2'd3;
      end else if (expire) begin
        reply <= {8'h45, 24'h0};
        tx_last <= 2'd0;
      end else if (send) reply <= reply << 8;
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: directed tests with UART and Wishbone slave models
module tb_uart_wb_bridge;
  logic clk = 0, reset = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_avail = 0, rx_ack, tx_wr, tx_busy = 0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = 0, jump_adr;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i = 0, jump_stb;
  int n_chk = 0, n_pass = 0;
  int ack_delay = 0, no_ack = 0, stb_n = 0, wb_cycles = 0, cyc_cycles = 0, jump_cnt = 0;
  logic [31:0] rd_data = 0, last_adr = 0, last_dat = 0, jump_seen = 0;
  logic last_we = 0;
  logic [3:0] last_sel = 0;
  logic [7:0] q[$];

  uart_wb_bridge #(.rx_timeout(40), .wb_timeout(255)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .jump_adr(jump_adr), .jump_stb(jump_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_data = b;
    rx_avail = 1;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      got = rx_ack;
    end
    rx_avail = 0;
    if (!got) check("rx_ack_timeout", 0, 1);
  endtask

  task automatic send_cmd(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_tx(input string tag, input int n);
    for (int i = 0; i < 2000 && q.size() < n; i++) tick();
    repeat (20) tick();
    check(tag, q.size(), n);
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_wr) begin
      q.push_back(tx_data);
      tx_busy = 1;
      repeat (3) @(negedge clk);
      tx_busy = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    wb_ack_i = 0;
    if (jump_stb) begin
      jump_cnt++;
      jump_seen = jump_adr;
    end
    if (wb_cyc_o && wb_stb_o) begin
      cyc_cycles++;
      if (stb_n == 0) begin
        wb_cycles++;
        last_adr = wb_adr_o;
        last_dat = wb_dat_o;
        last_we = wb_we_o;
        last_sel = wb_sel_o;
      end
      if (no_ack == 0 && stb_n == ack_delay) begin
        wb_ack_i = 1;
        wb_dat_i = rd_data;
      end
      stb_n++;
    end else stb_n = 0;
  end

  initial begin
    int w0;
    repeat (3) tick();
    check("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check("rst_strobes", {rx_ack, tx_wr, jump_stb}, 0);
    check("rst_sel", wb_sel_o, 4'hF);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_jump_adr", jump_adr, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 0;
    tick();

    ack_delay = 2;
    cyc_cycles = 0;
    send_cmd('{8'h55, 8'h77, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    wait_tx("wr_reply_count", 1);
    check("wr_reply", q[0], 8'h6B);
    check("wr_cycles", wb_cycles, 1);
    check("wr_adr", last_adr, 32'h0000_1000);
    check("wr_dat", last_dat, 32'hDEAD_BEEF);
    check("wr_we", last_we, 1);
    check("wr_sel", last_sel, 4'hF);
    check("wr_cyc_len", cyc_cycles, 3);

    q.delete();
    ack_delay = 0;
    rd_data = 32'h1234_5678;
    cyc_cycles = 0;
    send_cmd('{8'h72, 8'h00, 8'h00, 8'h10, 8'h00});
    wait_tx("rd_reply_count", 4);
    check("rd_b0", q[0], 8'h12);
    check("rd_b1", q[1], 8'h34);
    check("rd_b2", q[2], 8'h56);
    check("rd_b3", q[3], 8'h78);
    check("rd_cyc_len", cyc_cycles, 1);
    check("rd_we", last_we, 0);
    check("rd_adr", last_adr, 32'h0000_1000);

    q.delete();
    w0 = wb_cycles;
    send_cmd('{8'h67, 8'h40, 8'h00, 8'h00, 8'h00});
    repeat (30) tick();
    check("jmp_stb_len", jump_cnt, 1);
    check("jmp_adr_at_stb", jump_seen, 32'h4000_0000);
    check("jmp_adr", jump_adr, 32'h4000_0000);
    check("jmp_no_tx", q.size(), 0);
    check("jmp_no_wb", wb_cycles, w0);

    rd_data = 32'hAABB_CCDD;
    w0 = wb_cycles;
    send_cmd('{8'h72, 8'h00, 8'h00});
    repeat (60) tick();
    check("rxto_no_wb", wb_cycles, w0);
    send_cmd('{8'h72, 8'h00, 8'h00, 8'h00, 8'h04});
    wait_tx("rxto_reply_count", 4);
    check("rxto_one_wb", wb_cycles, w0 + 1);
    check("rxto_adr", last_adr, 32'h0000_0004);
    check("rxto_b0", q[0], 8'hAA);
    check("rxto_b3", q[3], 8'hDD);

    q.delete();
    no_ack = 1;
    cyc_cycles = 0;
    send_cmd('{8'h72, 8'h00, 8'h00, 8'h20, 8'h00});
    wait_tx("wbto_reply_count", 1);
    check("wbto_reply", q[0], 8'h45);
    check("wbto_cyc_len", cyc_cycles, 255);

    q.delete();
    send_cmd('{8'h77, 8'h00, 8'h00, 8'h30, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    for (int i = 0; i < 100 && !wb_cyc_o; i++) tick();
    check("rst_mid_cyc_seen", wb_cyc_o, 1);
    repeat (5) tick();
    reset = 1;
    tick();
    check("rst_mid_cyc", {wb_cyc_o, wb_stb_o}, 0);
    reset = 0;
    repeat (300) tick();
    check("rst_mid_no_reply", q.size(), 0);
    check("rst_mid_idle", wb_cyc_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
